gonso_sequencer: RTL and testbench
==================================

Name: gonso_sequencer

Overview:
- Fills the sequencer role behind the gonso register block.
- On a start strobe it walks the byte SRAM read port (port 1: cs1_n/addr1/rdata1) from w_first to w_last, and repeats the walk w_count times.
- Each byte read is presented downstream over a valid/ready stream.
- progress stays high for the whole run. Its falling edge is what the register block turns into irq.

Parameters:
- ASIZE, 32, SRAM address width (bits); must match the memory and register block.
- CSIZE, 4, pass-counter width (bits); must match the w_count width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start strobe from the register block
- abort  in  1  stop request; acts in any state
- w_count  in  CSIZE  number of passes
- w_first  in  ASIZE  first byte address
- w_last  in  ASIZE  last byte address (inclusive)
- progress  out  1  high while a run is active
- err  out  1  sticky flag: the last start was rejected
- pass_idx  out  CSIZE  index of the current pass (0-based)
- cs_n  out  1  SRAM read chip select, active low
- addr  out  ASIZE  SRAM read address
- rdata  in  8  SRAM read data
- byte_valid  out  1  output byte valid
- byte_data  out  8  output byte
- byte_last  out  1  marks the final byte of the final pass; qualified by byte_valid
- byte_ready  in  1  downstream accept

Behaviour:
- Clock and reset: clk only; rst_n is asynchronous and active-low.
- Reset values: state=IDLE, progress=0, err=0, pass_idx=0, addr=0, byte_valid=0, byte_data=0, byte_last=0. cs_n=1 (decoded from state).
- Reset mid-run: abandons the run immediately. No byte is delivered and progress falls.
- Memory model: 1-cycle read. addr is captured at the edge that ends a cycle with cs_n=0. rdata is valid during the following cycle and is sampled at the end of it.
- States: IDLE, REQ, WAIT, HOLD.
  - cs_n = 0 only in REQ.
  - addr is a register holding the current address.
  - byte_valid = 1 only in HOLD.
- IDLE:
  - On start with abort=0: check w_count != 0 and w_first <= w_last (unsigned).
  - Pass: latch w_first, w_last and w_count; set addr=w_first, pass_idx=0, err=0, progress=1; go to REQ.
  - Fail: err=1 and stay in IDLE. progress never rises, so no irq.
- REQ: always goes to WAIT next cycle.
- WAIT: capture byte_data<=rdata and set byte_last = (addr==last && pass_idx==count-1); go to HOLD.
- HOLD: hold byte_data stable while byte_ready=0. On byte_valid && byte_ready:
  - addr != last: addr<=addr+1, go to REQ.
  - addr == last and pass_idx < count-1: addr<=first, pass_idx++, go to REQ.
  - otherwise: go to IDLE with progress<=0.
- Throughput: 3 cycles per byte with byte_ready held high.
- Latency: start edge to first byte_valid is 3 cycles.
- Total run length: bytes per run = (last-first+1)*count.
- start while progress=1: ignored, and latched config is unchanged.
- abort (any state):
  - Next state is IDLE; progress=0 and byte_valid=0 in the next cycle.
  - err is unchanged and pass_idx holds its value.
  - abort and start in the same IDLE cycle: abort wins.
  - abort in the same cycle as a HOLD handshake: the byte counts as delivered, and the run still ends.
- Address arithmetic is modulo 2^ASIZE. w_last = all-ones and w_first = w_last (a single byte) are legal.
- The config inputs may change freely during a run; only the latched copies are used.

Decomposition:
- Shared package: the state encoding (IDLE/REQ/WAIT/HOLD, 2 bits) and the SRAM read latency constant (1).
- Sub-module: gonso_seq_addr_gen holds the address and pass counters. It exposes next/wrap/final signals, and the FSM consumes them.
- Everything else is flat in gonso_sequencer.

Test Plan:
- Preload SRAM[0x10..0x13]=A0,A1,A2,A3. Run first=0x10, last=0x13, count=1 with ready=1 → bytes A0..A3, byte_last only on A3. First byte_valid 3 cycles after start; progress high for 12 cycles.
- Run first=0x20, last=0x21, count=3 → sequence [20],[21] repeated three times. pass_idx steps 0,1,2; byte_last on the 6th byte only.
- Backpressure: hold byte_ready=0 for 5 cycles on byte 2 → byte_data stays stable and cs_n stays 1 throughout. No byte is lost or duplicated.
- Rejects: start with count=0, and separately with first=0x30, last=0x2F → err=1 and progress stays 0. A following valid start clears err.
- abort on the 2nd HOLD of a 4-byte run → progress=0 and byte_valid=0 next cycle. A new start afterwards begins again at w_first.
- Deassert rst_n asynchronously mid-WAIT → all outputs reach reset values with no clock edge. Restart after release behaves as in the first scenario.

Source files
------------

// File: rtl/gonso_sequencer_pkg.sv
// Shared definitions for the gonso read sequencer: FSM state encoding and
// the SRAM read latency the WAIT state is sized for.
package gonso_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_t;

  localparam int unsigned SRAM_RD_LATENCY = 1;

endpackage

// File: rtl/gonso_seq_addr_gen.sv
// Address and pass counters for the gonso sequencer. Holds the latched run
// configuration and reports where the walk stands so the FSM can decide.
module gonso_seq_addr_gen #(
  parameter int ASIZE = 32,
  parameter int CSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [ASIZE-1:0] first,
  input  logic [ASIZE-1:0] last,
  input  logic [CSIZE-1:0] count,
  output logic [ASIZE-1:0] addr,
  output logic [CSIZE-1:0] pass_idx,
  output logic             last_hit,
  output logic             wrap,
  output logic             final_byte
);

  logic [ASIZE-1:0] first_q;
  logic [ASIZE-1:0] last_q;
  logic [CSIZE-1:0] count_q;
  logic [ASIZE-1:0] addr_q;
  logic [CSIZE-1:0] pass_q;
  logic [ASIZE-1:0] addr_next;
  logic             final_pass;

  assign final_pass = (pass_q == (count_q - CSIZE'(1)));
  assign last_hit   = (addr_q == last_q);
  assign wrap       = last_hit && !final_pass;
  assign final_byte = last_hit && final_pass;
  // Wraps back to the first address at the end of each non-final pass.
  assign addr_next  = last_hit ? first_q : (addr_q + ASIZE'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
      last_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      pass_q  <= '0;
    end else if (load) begin
      first_q <= first;
      last_q  <= last;
      count_q <= count;
      addr_q  <= first;
      pass_q  <= '0;
    end else if (advance && !final_byte) begin
      addr_q <= addr_next;
      if (wrap) pass_q <= pass_q + CSIZE'(1);
    end
  end

  assign addr     = addr_q;
  assign pass_idx = pass_q;

endmodule

// File: rtl/gonso_sequencer.sv
// Walks the SRAM read port over [w_first..w_last] w_count times and streams
// each byte out over valid/ready; progress spans the whole run.
module gonso_sequencer #(
  parameter int ASIZE = 32,
  parameter int CSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CSIZE-1:0] w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  output logic             progress,
  output logic             err,
  output logic [CSIZE-1:0] pass_idx,
  output logic             cs_n,
  output logic [ASIZE-1:0] addr,
  input  logic [7:0]       rdata,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  input  logic             byte_ready
);

  import gonso_sequencer_pkg::*;

  // state | meaning
  // IDLE  | no run; accepts start
  // REQ   | chip select asserted, address presented
  // WAIT  | read data returning, captured at end of cycle
  // HOLD  | byte offered downstream until accepted

  seq_state_t state_q, state_d;
  logic       load;
  logic       advance;
  logic       reject;
  logic       cfg_ok;
  logic       last_hit;
  logic       wrap;
  logic       final_byte;

  assign cfg_ok = (w_count != '0) && (w_first <= w_last);

  gonso_seq_addr_gen #(
    .ASIZE(ASIZE),
    .CSIZE(CSIZE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .first     (w_first),
    .last      (w_last),
    .count     (w_count),
    .addr      (addr),
    .pass_idx  (pass_idx),
    .last_hit  (last_hit),
    .wrap      (wrap),
    .final_byte(final_byte)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    reject  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_d = ST_REQ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_HOLD;
      ST_HOLD: begin
        if (byte_ready) begin
          // An abort alongside the handshake still ends the run; counters freeze.
          advance = !abort;
          state_d = (!last_hit || wrap) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      progress  <= 1'b0;
      err       <= 1'b0;
      byte_data <= '0;
      byte_last <= 1'b0;
    end else begin
      state_q  <= state_d;
      progress <= (state_d != ST_IDLE);
      if (reject) begin
        err <= 1'b1;
      end else if (load) begin
        err <= 1'b0;
      end
      if (state_q == ST_WAIT) begin
        byte_data <= rdata;
        byte_last <= final_byte;
      end
    end
  end

  assign cs_n       = (state_q != ST_REQ);
  assign byte_valid = (state_q == ST_HOLD);

endmodule

// File: tb/tb_gonso_sequencer.sv
// Self-checking bench: a queue-based run model predicts every output each
// cycle; directed scenarios add literal expectations on top.
module tb_gonso_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  w_count;
  logic [31:0] w_first;
  logic [31:0] w_last;
  logic        progress;
  logic        err;
  logic [3:0]  pass_idx;
  logic        cs_n;
  logic [31:0] addr;
  logic [7:0]  rdata;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;

  gonso_sequencer #(.ASIZE(32), .CSIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .w_count   (w_count),
    .w_first   (w_first),
    .w_last    (w_last),
    .progress  (progress),
    .err       (err),
    .pass_idx  (pass_idx),
    .cs_n      (cs_n),
    .addr      (addr),
    .rdata     (rdata),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_last (byte_last),
    .byte_ready(byte_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1-cycle SRAM: address captured at the edge closing a cs_n=0 cycle.
  logic [7:0] mem [256];
  logic [7:0] rd_idx;
  always @(posedge clk) if (!cs_n) rd_idx <= addr[7:0];
  assign rdata = mem[rd_idx];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run model: a run is the list of (address, pass) items still to deliver.
  typedef struct {
    logic [31:0] a;
    logic [3:0]  p;
  } item_t;

  item_t m_q[$];
  bit    m_active;
  int    m_phase;   // cycles spent on the current byte so far
  bit    m_err;
  logic [3:0] m_pass;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_phase  = 0;
      m_err    = 0;
      m_pass   = '0;
      m_q.delete();
    end else if (m_active) begin
      if (abort) begin
        m_active = 0;
        m_q.delete();
      end else if (m_phase < 2) begin
        m_phase++;
      end else if (byte_ready) begin
        void'(m_q.pop_front());
        m_phase = 0;
        if (m_q.size() == 0) m_active = 0;
        else m_pass = m_q[0].p;
      end
    end else if (start && !abort) begin
      if (w_count != 0 && w_first <= w_last) begin
        for (int p = 0; p < int'(w_count); p++)
          for (longint a = longint'(w_first); a <= longint'(w_last); a++)
            m_q.push_back(item_t'{a[31:0], 4'(p)});
        m_active = 1;
        m_phase  = 0;
        m_err    = 0;
        m_pass   = '0;
      end else begin
        m_err = 1;
      end
    end
  end

  logic [7:0] got[$];
  logic [3:0] got_pass[$];
  bit         got_last[$];
  int         prog_cycles;

  always @(negedge clk) begin
    chk("progress", progress, m_active);
    chk("cs_n", cs_n, !(m_active && m_phase == 0));
    chk("byte_valid", byte_valid, m_active && m_phase == 2);
    chk("err", err, m_err);
    chk("pass_idx", pass_idx, m_pass);
    if (m_active && m_phase == 0) chk("addr", addr, m_q[0].a);
    if (m_active && m_phase == 2) begin
      chk("byte_data", byte_data, mem[m_q[0].a[7:0]]);
      chk("byte_last", byte_last, m_q.size() == 1);
    end
    if (progress) prog_cycles++;
    if (byte_valid && byte_ready) begin
      got.push_back(byte_data);
      got_pass.push_back(pass_idx);
      got_last.push_back(byte_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] f, input logic [31:0] l, input logic [3:0] c);
    w_first = f;
    w_last  = l;
    w_count = c;
    start   = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (progress === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (progress !== 1'b0) chk("wait_idle_timeout", progress, 1'b0);
  endtask

  task automatic clear_log();
    got.delete();
    got_pass.delete();
    got_last.delete();
    prog_cycles = 0;
  endtask

  // Four bytes A0..A3 at 0x10: latency, ordering, last flag, run length.
  task automatic run_basic();
    int lat = 0;
    clear_log();
    byte_ready = 1'b1;
    w_first = 32'h10;
    w_last  = 32'h13;
    w_count = 4'd1;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!byte_valid && lat < 20);
    chk("first_valid_latency", lat, 3);
    wait_idle(100);
    chk("basic_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("basic_data", got[i], 8'hA0 + 8'(i));
      chk("basic_last", got_last[i], i == 3);
    end
    chk("basic_progress_cycles", prog_cycles, 12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] f, l;
    logic [3:0]  c;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_ready = 1'b0;
    w_count = '0; w_first = '0; w_last = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1; mem[8'h12] = 8'hA2; mem[8'h13] = 8'hA3;
    mem[8'h20] = 8'h5A; mem[8'h21] = 8'hC3;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("rst_progress", progress, 1'b0);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_addr", addr, 32'h0);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_byte_data", byte_data, 8'h00);
    chk("rst_err", err, 1'b0);

    run_basic();

    // Two bytes, three passes.
    clear_log();
    do_start(32'h20, 32'h21, 4'd3);
    wait_idle(100);
    chk("multi_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      chk("multi_data", got[i], (i % 2 == 0) ? 8'h5A : 8'hC3);
      chk("multi_pass", got_pass[i], 4'(i / 2));
      chk("multi_last", got_last[i], i == 5);
    end

    // Backpressure on byte 2 for five cycles.
    clear_log();
    byte_ready = 1'b1;
    do_start(32'h10, 32'h13, 4'd1);
    n = 0;
    while (got.size() < 1 && n < 20) begin tick(); n++; end
    byte_ready = 1'b0;
    n = 0;
    while (!byte_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_data_stable", byte_data, 8'hA1);
      chk("bp_cs_n", cs_n, 1'b1);
      tick();
    end
    byte_ready = 1'b1;
    wait_idle(100);
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_data", got[i], 8'hA0 + 8'(i));

    // Rejected starts, then a good one clears err.
    do_start(32'h10, 32'h13, 4'd0);
    chk("rej_count_err", err, 1'b1);
    chk("rej_count_prog", progress, 1'b0);
    tick();
    do_start(32'h30, 32'h2F, 4'd2);
    chk("rej_order_err", err, 1'b1);
    chk("rej_order_prog", progress, 1'b0);
    do_start(32'h11, 32'h11, 4'd1);
    chk("accept_clears_err", err, 1'b0);
    wait_idle(100);

    // Abort on the second HOLD, with the handshake in the same cycle.
    clear_log();
    byte_ready = 1'b1;
    do_start(32'h10, 32'h13, 4'd1);
    n = 0;
    while (got.size() < 1 && n < 20) begin tick(); n++; end
    n = 0;
    while (!byte_valid && n < 20) begin tick(); n++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_progress", progress, 1'b0);
    chk("abort_valid", byte_valid, 1'b0);
    chk("abort_pass_hold", pass_idx, 4'd0);
    do_start(32'h10, 32'h13, 4'd1);
    chk("restart_addr", addr, 32'h10);
    chk("restart_cs_n", cs_n, 1'b0);
    wait_idle(100);

    // Single byte at the top of the address space, two passes.
    clear_log();
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    wait_idle(100);
    chk("top_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("top_last0", got_last[0], 1'b0);
      chk("top_last1", got_last[1], 1'b1);
      chk("top_data", got[1], mem[8'hFF]);
    end

    // Async reset in the middle of WAIT.
    do_start(32'h10, 32'h13, 4'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_progress", progress, 1'b0);
    chk("arst_cs_n", cs_n, 1'b1);
    chk("arst_valid", byte_valid, 1'b0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_pass", pass_idx, 4'd0);
    chk("arst_byte_data", byte_data, 8'h00);
    chk("arst_byte_last", byte_last, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    run_basic();

    // Randomized runs with random backpressure, aborts and stray starts.
    for (int r = 0; r < 25; r++) begin
      f = 32'h40 + 32'($urandom_range(0, 15));
      l = f + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) l = f - 32'd1;
      c = 4'($urandom_range(0, 3));
      byte_ready = 1'b1;
      do_start(f, l, c);
      n = 0;
      while (progress === 1'b1 && n < 400) begin
        byte_ready = ($urandom_range(0, 3) != 0);
        abort      = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 9) == 0) begin
          start   = 1'b1;
          w_first = $urandom;
          w_last  = $urandom;
          w_count = 4'($urandom);
        end
        tick();
        start = 1'b0;
        abort = 1'b0;
        n++;
      end
      if (progress !== 1'b0) chk("rand_timeout", progress, 1'b0);
      byte_ready = 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
